// File: rtl/load_use_scoreboard_if.sv
// ID-stage hazard bus: pipeline-side inputs and the pipeline control outputs.
interface load_use_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             ID_EX_MemRead;
    logic [REG_W-1:0] ID_EX_Rt;
    logic [REG_W-1:0] IF_ID_Rs;
    logic [REG_W-1:0] IF_ID_Rt;
    logic             IF_ID_UsesRs;
    logic             IF_ID_UsesRt;
    logic             MemWait;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             Stall;
    logic             Freeze;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt,
               IF_ID_UsesRs, IF_ID_UsesRt, MemWait,
        input  PCWrite, IF_ID_Write, Stall, Freeze, StallCount
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt,
               IF_ID_UsesRs, IF_ID_UsesRt, MemWait,
        output PCWrite, IF_ID_Write, Stall, Freeze, StallCount
    );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use hazard controller with a per-register scoreboard for multi-cycle loads,
// memory-wait freeze and a saturating stall-cycle counter.
module load_use_scoreboard_cell #(
    parameter int PW       = 1,
    parameter int LOAD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    input  logic mark,
    output logic busy
);
    logic [PW-1:0] pend;

    // A fresh mark overrides the decrement so a reload restarts the window.
    always_ff @(posedge clk) begin
        if (reset)
            pend <= '0;
        else if (advance) begin
            if (mark)
                pend <= PW'(LOAD_LAT - 1);
            else if (pend != '0)
                pend <= pend - PW'(1);
        end
    end

    assign busy = (pend != '0);
endmodule

module load_use_scoreboard #(
    parameter int REG_W    = 5,
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    load_use_scoreboard_if.slave bus
);
    localparam int PW = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;

    logic [NUM_REGS-1:1] busy;
    logic                sb_rs, sb_rt;
    logic                match_rs, match_rt;
    logic [CNT_W-1:0]    cnt;

    generate
        if (LOAD_LAT > 1) begin : g_sb
            logic advance;
            assign advance = ~bus.MemWait;
            for (genvar r = 1; r < NUM_REGS; r++) begin : g_cell
                load_use_scoreboard_cell #(.PW(PW), .LOAD_LAT(LOAD_LAT)) u_cell (
                    .clk     (clk),
                    .reset   (reset),
                    .advance (advance),
                    .mark    (bus.ID_EX_MemRead && (bus.ID_EX_Rt == REG_W'(r))),
                    .busy    (busy[r])
                );
            end
        end else begin : g_nosb
            assign busy = '0;
        end
    endgenerate

    // Sources beyond NUM_REGS-1 have no entry and never hit the scoreboard.
    always_comb begin
        sb_rs = 1'b0;
        sb_rt = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (bus.IF_ID_Rs == REG_W'(i) && busy[i]) sb_rs = 1'b1;
            if (bus.IF_ID_Rt == REG_W'(i) && busy[i]) sb_rt = 1'b1;
        end
    end

    assign match_rs = bus.IF_ID_UsesRs && (bus.IF_ID_Rs != '0) &&
                      ((bus.ID_EX_MemRead && (bus.ID_EX_Rt == bus.IF_ID_Rs)) || sb_rs);
    assign match_rt = bus.IF_ID_UsesRt && (bus.IF_ID_Rt != '0) &&
                      ((bus.ID_EX_MemRead && (bus.ID_EX_Rt == bus.IF_ID_Rt)) || sb_rt);

    always_comb begin
        bus.PCWrite     = 1'b1;
        bus.IF_ID_Write = 1'b1;
        bus.Stall       = 1'b0;
        bus.Freeze      = 1'b0;
        if (!reset) begin
            if (bus.MemWait) begin
                bus.Freeze      = 1'b1;
                bus.PCWrite     = 1'b0;
                bus.IF_ID_Write = 1'b0;
            end else if (match_rs || match_rt) begin
                bus.Stall       = 1'b1;
                bus.PCWrite     = 1'b0;
                bus.IF_ID_Write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if ((bus.Stall || bus.Freeze) && !(&cnt))
            cnt <= cnt + CNT_W'(1);
    end

    assign bus.StallCount = cnt;
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Drives three controllers (LOAD_LAT 1, 3, 4) with shared stimulus and checks each
// against a per-register "cycles until ready" model.
module tb_load_use_scoreboard;
    logic       clk = 1'b0;
    logic       reset;
    logic       mr, urs, urt, mw;
    logic [4:0] ext, rs, rt;

    always #5 clk = ~clk;

    load_use_scoreboard_if #(.REG_W(5), .CNT_W(16)) bus1 ();
    load_use_scoreboard_if #(.REG_W(5), .CNT_W(16)) bus3 ();
    load_use_scoreboard_if #(.REG_W(5), .CNT_W(4))  bus4 ();

    load_use_scoreboard #(.REG_W(5), .NUM_REGS(32), .LOAD_LAT(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    load_use_scoreboard #(.REG_W(5), .NUM_REGS(32), .LOAD_LAT(3), .CNT_W(16)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    load_use_scoreboard #(.REG_W(5), .NUM_REGS(32), .LOAD_LAT(4), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

    assign bus1.ID_EX_MemRead = mr;  assign bus3.ID_EX_MemRead = mr;  assign bus4.ID_EX_MemRead = mr;
    assign bus1.ID_EX_Rt = ext;      assign bus3.ID_EX_Rt = ext;      assign bus4.ID_EX_Rt = ext;
    assign bus1.IF_ID_Rs = rs;       assign bus3.IF_ID_Rs = rs;       assign bus4.IF_ID_Rs = rs;
    assign bus1.IF_ID_Rt = rt;       assign bus3.IF_ID_Rt = rt;       assign bus4.IF_ID_Rt = rt;
    assign bus1.IF_ID_UsesRs = urs;  assign bus3.IF_ID_UsesRs = urs;  assign bus4.IF_ID_UsesRs = urs;
    assign bus1.IF_ID_UsesRt = urt;  assign bus3.IF_ID_UsesRt = urt;  assign bus4.IF_ID_UsesRt = urt;
    assign bus1.MemWait = mw;        assign bus3.MemWait = mw;        assign bus4.MemWait = mw;

    // {PCWrite, IF_ID_Write, Stall, Freeze}
    logic [3:0] o[3];
    logic [15:0] c[3];
    assign o[0] = {bus1.PCWrite, bus1.IF_ID_Write, bus1.Stall, bus1.Freeze};
    assign o[1] = {bus3.PCWrite, bus3.IF_ID_Write, bus3.Stall, bus3.Freeze};
    assign o[2] = {bus4.PCWrite, bus4.IF_ID_Write, bus4.Stall, bus4.Freeze};
    assign c[0] = bus1.StallCount;
    assign c[1] = bus3.StallCount;
    assign c[2] = {12'd0, bus4.StallCount};

    int lat[3]  = '{1, 3, 4};
    int cmax[3] = '{65535, 65535, 15};
    int rem[3][32];
    int cnt[3];
    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit haz(int d, logic [4:0] r, logic u);
        return u && r != 0 && ((mr && ext == r) || rem[d][r] > 0);
    endfunction

    function automatic logic [3:0] exp_out(int d);
        if (reset) return 4'b1100;
        if (mw) return 4'b0001;
        if (haz(d, rs, urs) || haz(d, rt, urt)) return 4'b0010;
        return 4'b1100;
    endfunction

    task automatic step(input logic i_mr, input logic [4:0] i_ext, input logic [4:0] i_rs,
                        input logic [4:0] i_rt, input logic i_urs, input logic i_urt,
                        input logic i_mw, input logic i_rst);
        logic [3:0] e;
        mr = i_mr; ext = i_ext; rs = i_rs; rt = i_rt;
        urs = i_urs; urt = i_urt; mw = i_mw; reset = i_rst;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("ctl_lat%0d", lat[d]), 32'(o[d]), 32'(exp_out(d)));
            chk($sformatf("cnt_lat%0d", lat[d]), 32'(c[d]), 32'(cnt[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            e = exp_out(d);
            if (reset) begin
                cnt[d] = 0;
                for (int r = 0; r < 32; r++) rem[d][r] = 0;
            end else begin
                if ((e[1] || e[0]) && cnt[d] < cmax[d]) cnt[d]++;
                if (!mw) begin
                    for (int r = 0; r < 32; r++) if (rem[d][r] > 0) rem[d][r]--;
                    if (mr && ext != 0) rem[d][ext] = lat[d] - 1;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [4:0] pick();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd5;
            2: return 5'd9;
            3: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        mr = 0; ext = 0; rs = 0; rt = 0; urs = 0; urt = 0; mw = 0; reset = 1;
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0;
            for (int r = 0; r < 32; r++) rem[d][r] = 0;
        end
        @(posedge clk);
        @(negedge clk);

        // Classic bubble: lw $5 in EX, add $6,$5,$7 in ID.
        step(1, 5, 5, 7, 1, 1, 0, 0);
        chk("classic_cnt_lat1", 32'(c[0]), 32'd1);
        step(0, 0, 5, 7, 1, 1, 0, 0);
        step(0, 0, 5, 7, 1, 1, 0, 0);
        step(0, 0, 5, 7, 1, 1, 0, 0);
        chk("long_cnt_lat3", 32'(c[1]), 32'd3);

        // Operand qualification and $0.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 5, 8, 5, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("opq_cnt_lat4", 32'(c[2]), 32'd0);

        // MemWait in the second stall cycle for two cycles.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 5, 5, 0, 1, 0, 0, 0);
        step(0, 0, 5, 0, 1, 0, 1, 0);
        step(0, 0, 5, 0, 1, 0, 1, 0);
        step(0, 0, 5, 0, 1, 0, 0, 0);
        step(0, 0, 5, 0, 1, 0, 0, 0);
        chk("memwait_cnt_lat3", 32'(c[1]), 32'd5);
        step(0, 0, 5, 0, 1, 0, 0, 0);

        // Same-register reload, consumer arrives after both loads.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 9, 1, 2, 0, 0, 0, 0);
        step(1, 9, 1, 2, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 9, 3, 1, 1, 0, 0);
        chk("reload_cnt_lat4", 32'(c[2]), 32'd3);

        // Reset in the middle of a stall.
        step(1, 9, 9, 0, 1, 0, 0, 0);
        step(0, 0, 9, 0, 1, 0, 0, 0);
        step(0, 0, 9, 0, 1, 0, 0, 1);
        chk("rst_cnt_lat4", 32'(c[2]), 32'd0);
        step(0, 0, 9, 0, 1, 0, 0, 0);
        step(0, 0, 9, 9, 1, 1, 0, 0);

        // Randomized traffic, with rare resets.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 4, pick(), pick(), pick(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
